// File: rtl/mem_init_seq_if.sv
// Bus bundle between the memory-init sequencer, its controller and the RAM pins.
interface mem_init_seq_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();
    logic          start;
    logic [1:0]    mode;
    logic [DW-1:0] fill_value;
    logic          verify_en;
    logic [DW-1:0] q;
    logic          wren;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic          verify_error;
    logic [AW-1:0] error_addr;

    modport master (
        input  start, mode, fill_value, verify_en, q,
        output wren, address, data, busy, done, verify_error, error_addr
    );

    modport slave (
        output start, mode, fill_value, verify_en, q,
        input  wren, address, data, busy, done, verify_error, error_addr
    );
endinterface

// File: rtl/mem_init_seq.sv
// Memory-initialisation sequencer: fills DEPTH RAM words with a selectable
// pattern, then optionally reads them back and flags the first mismatch.
module mem_init_seq #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic           clock,
    input  logic           restart,
    mem_init_seq_if.master bus
);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = AW + DW;
    localparam int unsigned WW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] LAST      = CW'(DEPTH - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(READ_LAT);

    typedef enum logic [2:0] {IDLE, FILL, RD_ISSUE, RD_WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    mode_q;
    logic [DW-1:0] fill_q;
    logic          verify_q;

    // Pattern is formed at AW+DW bits so reverse never underflows before truncation.
    function automatic logic [DW-1:0] pattern(input logic [1:0] m,
                                              input logic [DW-1:0] fv,
                                              input logic [CW-1:0] a);
        logic [PW-1:0] ax;
        logic [PW-1:0] fx;
        logic [PW-1:0] r;
        ax = PW'(a);
        fx = PW'(fv);
        case (m)
            2'b00:   r = ax;
            2'b01:   r = fx;
            2'b10:   r = ax ^ fx;
            default: r = PW'(DEPTH - 1) - ax;
        endcase
        return DW'(r);
    endfunction

    always_ff @(posedge clock) begin
        if (restart) begin
            state            <= IDLE;
            cnt              <= '0;
            wait_cnt         <= '0;
            mode_q           <= '0;
            fill_q           <= '0;
            verify_q         <= 1'b0;
            bus.wren         <= 1'b0;
            bus.address      <= '0;
            bus.data         <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.verify_error <= 1'b0;
            bus.error_addr   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q           <= bus.mode;
                        fill_q           <= bus.fill_value;
                        verify_q         <= bus.verify_en;
                        bus.verify_error <= 1'b0;
                        bus.error_addr   <= '0;
                        cnt              <= '0;
                        bus.wren         <= 1'b1;
                        bus.address      <= '0;
                        bus.data         <= pattern(bus.mode, bus.fill_value, CW'(0));
                        bus.busy         <= 1'b1;
                        state            <= FILL;
                    end
                end
                FILL: begin
                    if (cnt == LAST) begin
                        cnt         <= '0;
                        bus.wren    <= 1'b0;
                        bus.address <= '0;
                        bus.data    <= '0;
                        if (verify_q) begin
                            state <= RD_ISSUE;
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        cnt         <= cnt + CW'(1);
                        bus.address <= AW'(cnt + CW'(1));
                        bus.data    <= pattern(mode_q, fill_q, cnt + CW'(1));
                    end
                end
                RD_ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt != WW'(1)) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end else begin
                        // Only the first mismatch is recorded; later ones leave error_addr alone.
                        if ((bus.q != pattern(mode_q, fill_q, cnt)) && !bus.verify_error) begin
                            bus.verify_error <= 1'b1;
                            bus.error_addr   <= AW'(cnt);
                        end
                        if (cnt == LAST) begin
                            bus.address <= '0;
                            bus.busy    <= 1'b0;
                            bus.done    <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt         <= cnt + CW'(1);
                            bus.address <= AW'(cnt + CW'(1));
                            state       <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_init_seq.sv
// Bench for mem_init_seq: table-driven fills on a 256-deep instance with a write
// scoreboard, plus hand sequences for verify errors, reset, start overlap and small depths.
module tb_mem_init_seq;
    logic clock;
    logic restart;
    int   checks;
    int   failures;

    mem_init_seq_if #(.AW(8), .DW(8)) bus0 ();
    mem_init_seq_if #(.AW(8), .DW(8)) bus1 ();
    mem_init_seq_if #(.AW(8), .DW(8)) bus2 ();
    mem_init_seq_if #(.AW(4), .DW(8)) bus3 ();

    mem_init_seq #(.AW(8), .DW(8), .DEPTH(256), .READ_LAT(1)) u0 (.clock(clock), .restart(restart), .bus(bus0));
    mem_init_seq #(.AW(8), .DW(8), .DEPTH(256), .READ_LAT(2)) u1 (.clock(clock), .restart(restart), .bus(bus1));
    mem_init_seq #(.AW(8), .DW(8), .DEPTH(1),   .READ_LAT(1)) u2 (.clock(clock), .restart(restart), .bus(bus2));
    mem_init_seq #(.AW(4), .DW(8), .DEPTH(16),  .READ_LAT(1)) u3 (.clock(clock), .restart(restart), .bus(bus3));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM models: u0 ideal 1-cycle, u1 2-cycle with corrupted words at 17 and 200.
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] rd1;
    always @(posedge clock) begin
        if (bus0.wren) mem0[bus0.address] <= bus0.data;
        bus0.q <= mem0[bus0.address];
        if (bus1.wren) mem1[bus1.address] <= bus1.data;
        rd1 <= mem1[bus1.address] ^ (((bus1.address == 8'd17) || (bus1.address == 8'd200)) ? 8'h01 : 8'h00);
        bus1.q <= rd1;
    end
    assign bus2.q = 8'h00;
    assign bus3.q = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] fv, input int a);
        case (m)
            2'b00:   return 8'(a);
            2'b01:   return fv;
            2'b10:   return 8'(a) ^ fv;
            default: return 8'(255 - a);
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb[$];

    task automatic push_seq(input logic [1:0] m, input logic [7:0] fv);
        for (int k = 0; k < 256; k++) sb.push_back({8'(k), model(m, fv, k)});
    endtask

    // Write scoreboard for u0: every write must match the next expected entry.
    always @(negedge clock) begin
        wr_t e;
        if (bus0.wren === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h/%0h required=none", bus0.address, bus0.data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus0.address), 32'(e.addr));
                check("wr_data", 32'(bus0.data), 32'(e.data));
            end
        end
    end

    typedef struct {
        logic [1:0] mode;
        logic [7:0] fv;
        logic       ven;
        logic [7:0] d3;
        int         done_at;
    } vec_t;
    vec_t vecs[5];

    task automatic run0(input vec_t v);
        int done_at;
        int busy_bad;
        done_at  = -1;
        busy_bad = 0;
        @(negedge clock);
        bus0.mode = v.mode; bus0.fill_value = v.fv; bus0.verify_en = v.ven; bus0.start = 1'b1;
        push_seq(v.mode, v.fv);
        @(posedge clock);
        for (int k = 1; k <= 2000 && done_at < 0; k++) begin
            @(negedge clock); #1;
            if (k == 1) begin
                bus0.start = 1'b0; bus0.mode = ~v.mode; bus0.fill_value = ~v.fv; bus0.verify_en = ~v.ven;
            end
            if (k == 4) begin
                check("addr3", 32'(bus0.address), 32'd3);
                check("data3", 32'(bus0.data), 32'(v.d3));
            end
            if (v.ven && k == 259) check("rd_cadence", 32'({bus0.wren, bus0.address}), 32'd1);
            if (bus0.done) done_at = k;
            else if (!bus0.busy) busy_bad++;
        end
        check("done_cycle", 32'(done_at), 32'(v.done_at));
        check("busy_gaps", 32'(busy_bad), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("verify_error0", 32'(bus0.verify_error), 32'd0);
        @(negedge clock); #1;
        check("done_one_cycle", 32'({bus0.done, bus0.busy}), 32'd0);
    endtask

    task automatic run2(input logic ven, input int exp_done, input logic exp_err);
        int done_at;
        int wr;
        done_at = -1;
        wr      = 0;
        @(negedge clock);
        bus2.mode = 2'b01; bus2.fill_value = 8'h5A; bus2.verify_en = ven; bus2.start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 20 && done_at < 0; k++) begin
            @(negedge clock); #1;
            if (k == 1) bus2.start = 1'b0;
            if (bus2.wren) begin
                wr++;
                check("d1_write", 32'({bus2.address, bus2.data}), 32'h005A);
            end
            if (bus2.done) done_at = k;
        end
        check("d1_writes", 32'(wr), 32'd1);
        check("d1_done", 32'(done_at), 32'(exp_done));
        check("d1_err", 32'({bus2.verify_error, bus2.error_addr}), 32'({exp_err, 8'h00}));
    endtask

    initial begin
        int d1;
        int d2;
        int done_at;
        int wr;
        int bad;
        checks   = 0;
        failures = 0;
        restart  = 1'b1;
        bus0.start = 0; bus0.mode = 0; bus0.fill_value = 0; bus0.verify_en = 0;
        bus1.start = 0; bus1.mode = 0; bus1.fill_value = 0; bus1.verify_en = 0;
        bus2.start = 0; bus2.mode = 0; bus2.fill_value = 0; bus2.verify_en = 0;
        bus3.start = 0; bus3.mode = 0; bus3.fill_value = 0; bus3.verify_en = 0;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("reset_u0", 32'({bus0.wren, bus0.address, bus0.data, bus0.busy, bus0.done, bus0.verify_error, bus0.error_addr}), 32'd0);
        check("reset_u3", 32'({bus3.wren, bus3.address, bus3.data, bus3.busy, bus3.done, bus3.verify_error, bus3.error_addr}), 32'd0);
        restart = 1'b0;

        vecs[0] = '{2'b00, 8'h00, 1'b0, 8'h03, 257};
        vecs[1] = '{2'b10, 8'hA5, 1'b1, 8'hA6, 769};
        vecs[2] = '{2'b01, 8'h3C, 1'b0, 8'h3C, 257};
        vecs[3] = '{2'b11, 8'h5A, 1'b0, 8'hFC, 257};
        vecs[4] = '{2'b10, 8'hFF, 1'b1, 8'hFC, 769};
        foreach (vecs[i]) run0(vecs[i]);

        // Constant fill with 2-cycle RAM and two corrupted words.
        @(negedge clock);
        bus1.mode = 2'b01; bus1.fill_value = 8'h3C; bus1.verify_en = 1'b1; bus1.start = 1'b1;
        @(posedge clock);
        done_at = -1;
        for (int k = 1; k <= 1500 && done_at < 0; k++) begin
            @(negedge clock); #1;
            if (k == 1) bus1.start = 1'b0;
            if (k == 18) check("u1_wr17", 32'({bus1.wren, bus1.address, bus1.data}), 32'({1'b1, 8'd17, 8'h3C}));
            if (bus1.done) done_at = k;
        end
        check("u1_done", 32'(done_at), 32'd1025);
        check("u1_err", 32'({bus1.verify_error, bus1.error_addr}), 32'({1'b1, 8'd17}));
        @(negedge clock); #1;
        check("u1_err_sticky", 32'({bus1.verify_error, bus1.error_addr}), 32'({1'b1, 8'd17}));
        bus1.mode = 2'b00; bus1.verify_en = 1'b0; bus1.start = 1'b1;
        @(negedge clock); #1;
        bus1.start = 1'b0;
        check("u1_err_clear", 32'({bus1.verify_error, bus1.error_addr, bus1.busy}), 32'd1);
        repeat (300) @(negedge clock);

        // Reset in the cycle that writes address 40.
        @(negedge clock);
        bus0.mode = 2'b00; bus0.fill_value = 8'h00; bus0.verify_en = 1'b0; bus0.start = 1'b1;
        push_seq(2'b00, 8'h00);
        @(posedge clock);
        for (int k = 1; k <= 41; k++) begin
            @(negedge clock); #1;
            if (k == 1) bus0.start = 1'b0;
        end
        check("rst_at40", 32'({bus0.wren, bus0.address}), 32'({1'b1, 8'd40}));
        restart = 1'b1;
        sb.delete();
        @(negedge clock); #1;
        check("rst_mid", 32'({bus0.wren, bus0.address, bus0.busy, bus0.done}), 32'd0);
        restart = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock); #1;
            if (bus0.done || bus0.wren || bus0.busy) bad++;
        end
        check("rst_quiet", 32'(bad), 32'd0);
        run0(vecs[0]);

        // Start during FILL is ignored; start held across DONE relaunches.
        @(negedge clock);
        bus0.mode = 2'b00; bus0.fill_value = 8'h77; bus0.verify_en = 1'b0; bus0.start = 1'b1;
        push_seq(2'b00, 8'h00);
        push_seq(2'b00, 8'h00);
        @(posedge clock);
        d1 = -1;
        d2 = -1;
        for (int k = 1; k <= 700 && d2 < 0; k++) begin
            @(negedge clock); #1;
            if (k == 1) bus0.start = 1'b0;
            if (k == 10) begin bus0.start = 1'b1; bus0.mode = 2'b01; end
            if (k == 11) bus0.start = 1'b0;
            if (k == 200) begin bus0.start = 1'b1; bus0.mode = 2'b00; end
            if (k == 258) check("idle_gap", 32'({bus0.done, bus0.busy, bus0.wren}), 32'd0);
            if (k == 259) bus0.start = 1'b0;
            if (bus0.done) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
        end
        check("overlap_done1", 32'(d1), 32'd257);
        check("overlap_done2", 32'(d2), 32'd515);
        check("overlap_sb", 32'(sb.size()), 32'd0);

        // DEPTH=1: fill only, then fill + verify reading back 0 against 5A.
        run2(1'b0, 2, 1'b0);
        run2(1'b1, 4, 1'b1);

        // DEPTH=16, AW=4, reverse pattern.
        @(negedge clock);
        bus3.mode = 2'b11; bus3.fill_value = 8'h00; bus3.verify_en = 1'b0; bus3.start = 1'b1;
        @(posedge clock);
        done_at = -1;
        wr      = 0;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            @(negedge clock); #1;
            if (k == 1) begin
                bus3.start = 1'b0;
                check("rev_first", 32'({bus3.address, bus3.data}), 32'({4'd0, 8'd15}));
            end
            if (k == 16) check("rev_last", 32'({bus3.address, bus3.data}), 32'({4'd15, 8'd0}));
            if (bus3.wren) begin
                wr++;
                check("rev_data", 32'(bus3.data), 32'(8'(15 - int'(bus3.address))));
            end
            if (bus3.done) done_at = k;
        end
        check("rev_writes", 32'(wr), 32'd16);
        check("rev_done", 32'(done_at), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_init_seq.md
Name: mem_init_seq

Overview:
- Parametrised memory-initialisation sequencer. It fills a single-port RAM with a selectable pattern over DEPTH addresses.
- An optional read-back verify pass can follow the fill.
- Sits between control logic and the RAM's address/data/wren/q pins, for example for S-array initialisation in the RC4 datapath.
- Issues one write per cycle and reports completion with a done pulse. Flags the first verify mismatch.

Parameters:
AW, 8, address width in bits.
DW, 8, data width in bits.
DEPTH, 256, number of locations initialised, from address 0 to DEPTH-1. Must satisfy 1 <= DEPTH <= 2**AW.
READ_LAT, 1, RAM read latency in clock cycles (address to q). Must satisfy READ_LAT >= 1.

Ports:
clock  in  1  system clock; all logic is on the rising edge.
restart  in  1  synchronous reset, active-high.
start  in  1  request to begin a sequence; sampled only in IDLE.
mode  in  2  pattern select: 00 identity, 01 constant, 10 xor, 11 reverse. Latched at start.
fill_value  in  DW  operand for the constant and xor patterns. Latched at start.
verify_en  in  1  when 1, a read-back verify pass runs after the fill. Latched at start.
q  in  DW  RAM read data.
wren  out  1  RAM write enable.
address  out  AW  RAM address.
data  out  DW  RAM write data.
busy  out  1  high while in FILL, RD_ISSUE or RD_WAIT.
done  out  1  one-cycle completion pulse.
verify_error  out  1  sticky mismatch flag; cleared by the next accepted start or by restart.
error_addr  out  AW  address of the first mismatch; cleared by the next accepted start or by restart.

Behaviour:
- Reset (restart=1 at a clock edge):
  - state becomes IDLE.
  - wren, address, data, busy, done, verify_error and error_addr are all 0.
  - Reset overrides every other input, including mid-sequence. No further writes are issued after the reset edge.
- Pattern p(a) for address a. Compute in AW+DW bits, then take the low DW bits; zero-extend a when DW > AW.
  - identity: p(a) = a.
  - constant: p(a) = fill_value.
  - xor: p(a) = a XOR fill_value.
  - reverse: p(a) = DEPTH-1-a.
- State machine: IDLE, FILL, RD_ISSUE, RD_WAIT, DONE.
- IDLE:
  - Outputs are 0.
  - If start=1 at edge N: latch mode, fill_value and verify_en; clear verify_error and error_addr; load the counter with 0; move to FILL.
- FILL:
  - wren=1, address=counter, data=p(counter).
  - Writes to addresses 0..DEPTH-1 occur in cycles N+1..N+DEPTH, one per cycle with no gaps.
  - After the write to DEPTH-1: if verify_en=0, go to DONE. Otherwise reset the counter to 0 and go to RD_ISSUE.
- RD_ISSUE:
  - wren=0, address=counter, data=0.
  - Go to RD_WAIT with a wait count of READ_LAT.
- RD_WAIT:
  - address is held and wren=0.
  - When the wait count expires, q is valid and is compared with p(counter).
  - On mismatch with verify_error=0: set verify_error=1 and error_addr=counter.
  - Later mismatches do not change error_addr.
  - If counter = DEPTH-1, go to DONE. Otherwise increment the counter and go to RD_ISSUE.
  - Each verified address takes READ_LAT+1 cycles; the verify pass is not pipelined.
- DONE:
  - done=1 for exactly one cycle, busy=0, wren=0.
  - Next state is IDLE.
  - verify_error and error_addr stay valid until the next accepted start.
- Latency:
  - Fill only: done asserts in cycle N+DEPTH+1.
  - With verify: done asserts in cycle N+DEPTH+DEPTH*(READ_LAT+1)+1.
- start outside IDLE is ignored, including in DONE. A start held high across DONE is accepted in the following IDLE cycle.
- Changes to mode, fill_value and verify_en after start have no effect on the sequence in progress.
- Counter is AW+1 bits wide, so DEPTH = 2**AW terminates without wrap-around.
- DEPTH=1: a single write, then done (or a single verify read, then done).

Test Plan:
1. Identity fill. Defaults, mode=00, verify_en=0, start for one cycle at N. Required:
   - 256 consecutive wren cycles; address k and data k in cycle N+1+k.
   - done=1 only in cycle N+257; busy is 0 before and after.
2. xor fill with an ideal RAM model (READ_LAT=1, no injected errors). mode=10, fill_value=8'hA5, verify_en=1. Required:
   - Writes address 3 with data 8'hA6.
   - 256 reads at a 2-cycle cadence.
   - verify_error=0 and done at cycle N+256+512+1.
3. Error injection. mode=01, fill_value=8'h3C, READ_LAT=2, RAM model corrupts addresses 17 and 200. Required:
   - verify_error=1 and error_addr=17 at done.
   - Flags clear when the next start is accepted.
4. Reset mid-fill. restart=1 at the write to address 40. Required:
   - wren=0, address=0, busy=0 from the next cycle.
   - No done pulse.
   - A new start then writes from address 0.
5. Start ignored while busy. Pulse start during FILL with mode=01. Required:
   - The pattern stays identity and the sequence length is unchanged.
   - start held high through DONE launches a second sequence in the following IDLE cycle.
6. Boundaries. DEPTH=1, and AW=4 with DW=8 at DEPTH=16, mode=11. Required:
   - DEPTH=1: exactly one write, then done.
   - DEPTH=16 reverse: address 0 gets data 15, address 15 gets data 0, with no counter wrap.
